spu_line_fetch: RTL and testbench

Sequencer that sits directly upstream of the memory hierarchy's SPU read port. It accepts a vector-load request (base byte address, line count), drives the SPU read address one 128-bit line per cycle, tracks the hierarchy's fixed read latency, and buffers the returned lines in a small FIFO for the SPU datapath. Issue is credit-limited so no returned line is ever dropped under SPU back-pressure.

---
 rtl/spu_line_fetch.sv | 172 +++++++++++++++++
 tb/tb_spu_line_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spu_line_fetch.sv
// spu_line_fetch: issues one line-read address per cycle to the SPU read port,
// tracks the fixed read latency and buffers the returned lines in a small FIFO.
// Reads are only issued while the FIFO has room for every line in flight.
module spu_line_fetch #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 128,
    parameter int LEN_W      = 8,
    parameter int STRIDE     = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [LEN_W-1:0]  req_len,
    output logic [ADDR_W-1:0] spu_addr,
    input  logic [DATA_W-1:0] spu_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic              zero_len;

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] last_sr;

    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      inflight;

    logic issue;
    logic line_last;
    logic push;
    logic pop;

    // Number of reads issued whose data has not yet been written to the FIFO.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_sr[i]);
        end
    end

    // A same-cycle pop is deliberately not credited, so the FIFO cannot overflow.
    assign issue     = (state == ISSUE) && (issued < len_q) &&
                       ((fifo_count + inflight) < CNT_W'(FIFO_DEPTH));
    assign line_last = (issued == (len_q - LEN_W'(1)));
    assign spu_addr  = issue ? next_addr : last_addr;

    assign push      = vld_sr[RD_LAT-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign busy      = (state != IDLE);

    // Request sequencing: accept, issue line addresses, wait for the final pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            done      <= 1'b0;
            len_q     <= '0;
            issued    <= '0;
            next_addr <= '0;
            last_addr <= '0;
            zero_len  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        len_q     <= req_len;
                        issued    <= '0;
                        next_addr <= req_base;
                        if (req_len == '0) begin
                            // Nothing to read: report completion immediately.
                            state    <= DRAIN;
                            done     <= 1'b1;
                            zero_len <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            zero_len <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        last_addr <= next_addr;
                        next_addr <= next_addr + ADDR_W'(STRIDE);
                        issued    <= issued + LEN_W'(1);
                        if (line_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (zero_len) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        zero_len  <= 1'b0;
                    end else if (pop && out_last && (inflight == '0)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Latency pipeline and output FIFO; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr     <= '0;
            last_sr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && line_last;

            if (push) begin
                fifo_data[wr_ptr] <= spu_read_data;
                fifo_last[wr_ptr] <= last_sr[RD_LAT-1];
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_spu_line_fetch.sv
// Testbench for spu_line_fetch: a 1-cycle-latency memory model answers every
// address; expected line streams are built from base + i*16 per request.
module tb_spu_line_fetch;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_base = '0;
    logic [7:0]   req_len = '0;
    logic [31:0]  spu_addr;
    logic [127:0] spu_read_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_last = '0;

    typedef struct {
        logic [31:0] base;
        int          len;
        int          hold;
        int          rdy;
        logic [31:0] hold_addr;
        logic [31:0] last_addr;
        int          done_lat;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    spu_line_fetch #(
        .ADDR_W(32), .DATA_W(128), .LEN_W(8), .STRIDE(16), .RD_LAT(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_len(req_len),
        .spu_addr(spu_addr), .spu_read_data(spu_read_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1234_5678};
    endfunction

    // Memory: address seen in cycle k is answered throughout cycle k+1.
    initial begin
        logic [31:0] a;
        spu_read_data = '0;
        forever begin
            @(negedge clk);
            a = spu_addr;
            @(posedge clk);
            #1;
            spu_read_data = mem_line(a);
        end
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int waitc = 0;
        @(posedge clk); #1;
        while (!req_ready && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
    endtask

    task automatic run_req(input logic [31:0] base, input int len, input int hold,
                           input int rdy_pct, input logic [31:0] hold_addr,
                           input logic [31:0] last_addr, input int exp_done);
        logic [128:0] expq[$];
        bit finished;
        for (int i = 0; i < len; i++) begin
            expq.push_back({(i == len - 1), mem_line(base + 32'(i) * 32'd16)});
        end
        wait_ready();
        if (!req_ready) begin
            chk("req_ready_wait", req_ready, 1);
            return;
        end
        req_valid = 1'b1;
        req_base  = base;
        req_len   = 8'(len);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_base  = $urandom;
        req_len   = 8'($urandom);
        finished  = 1'b0;
        for (int k = 1; k <= 3000 && !finished; k++) begin
            out_ready = (k <= hold) ? 1'b0 : (($urandom % 100) < rdy_pct);
            @(negedge clk);
            if (k == 1 && len > 0) chk("first_addr", spu_addr, base);
            if (hold > 0 && k == hold) chk("held_addr", spu_addr, hold_addr);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("extra_line", out_valid, 0);
                end else begin
                    chk("line", {out_last, out_data}, expq[0]);
                    if (out_ready) void'(expq.pop_front());
                end
            end
            if (done) begin
                finished = 1'b1;
                if (exp_done > 0) chk("done_cycle", k, exp_done);
                chk("lines_left", expq.size(), 0);
                chk("last_addr", spu_addr, last_addr);
                if (len > 0) chk("ready_with_done", req_ready, 1);
            end
            @(posedge clk); #1;
        end
        if (!finished) begin
            chk("done_seen", finished, 1);
        end else begin
            @(negedge clk);
            chk("done_pulse", done, 0);
        end
        model_last = last_addr;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0040, 1,  0,  100, 32'h0, 32'h0000_0040, 4};
        vecs[1] = '{32'h5555_0000, 0,  0,  100, 32'h0, 32'h0000_0040, 1};
        vecs[2] = '{32'h0000_0000, 4,  0,  100, 32'h0, 32'h0000_0030, 7};
        vecs[3] = '{32'hFFFF_FFF0, 2,  0,  100, 32'h0, 32'h0000_0000, 5};
        vecs[4] = '{32'h0000_1000, 16, 0,  100, 32'h0, 32'h0000_10F0, 19};
        vecs[5] = '{32'h0000_0100, 8,  12, 100, 32'h0000_0130, 32'h0000_0170, 21};

        // Reset held for five cycles, released mid-clock.
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_addr", spu_addr, 0);
        chk("rst_out", {out_valid, out_last, out_data}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].base, vecs[i].len, vecs[i].hold, vecs[i].rdy,
                    vecs[i].hold_addr, vecs[i].last_addr, vecs[i].done_lat);
        end

        // Reset after the third line has been issued.
        out_ready = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_base  = 32'h0000_0200;
        req_len   = 8'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mid_addr", spu_addr, 32'h0000_0220);
        chk("mid_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out", {out_valid, out_last, out_data}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", spu_addr, 0);
        chk("mid_rst_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_last = '0;
        run_req(32'h0000_0300, 4, 0, 100, 32'h0, 32'h0000_0330, 7);

        // Randomized requests against the line-stream model.
        for (int r = 0; r < 25; r++) begin
            logic [31:0] b;
            int          l;
            int          p;
            logic [31:0] la;
            b  = $urandom;
            if (r % 5 == 0) b = 32'hFFFF_FF00 | (b & 32'h0000_00FF);
            l  = $urandom_range(0, 12);
            p  = $urandom_range(30, 100);
            la = (l > 0) ? (b + 32'(l - 1) * 32'd16) : model_last;
            run_req(b, l, 0, p, 32'h0, la, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
